// File: rtl/fft_channel_arbiter_pkg.sv
// Shared types and frame constants for the FFT channel arbiter.
package fft_channel_arbiter_pkg;

    localparam int unsigned FRAME_LOG2 = 9;
    localparam int unsigned FRAME_LEN  = 512;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ARB   = 4'd1,
        S_START = 4'd2,
        S_LOAD  = 4'd3,
        S_WAIT  = 4'd4,
        S_DRAIN = 4'd5
    } state_t;

endpackage

// File: rtl/fft_channel_arbiter_rr_arbiter2.sv
// Two-way round-robin choice; combinational, registered by the parent.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic [1:0] o_grant
);

    // On a tie the channel that was not served last wins
    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_served ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/fft_channel_arbiter.sv
// Shares one FFT core between two audio channels: arbitrate, start,
// load 512 samples, wait for results, then stream 512 tagged bins.
module fft_channel_arbiter #(
    parameter int unsigned FRAME_LOG2   = 9,
    parameter int unsigned WAIT_TIMEOUT = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_req,
    output logic [1:0]            o_grant,
    output logic                  o_rd_en,
    output logic                  o_fft_start,
    output logic                  o_fft_in_valid,
    input  logic                  i_fft_done,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [FRAME_LOG2-1:0] o_out_index,
    output logic                  o_out_ch,
    output logic                  o_frame_done,
    output logic                  o_timeout_err
);

    import fft_channel_arbiter_pkg::*;

    localparam int unsigned           WCW       = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCW-1:0]        WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);
    localparam logic [FRAME_LOG2-1:0] LAST_IDX  = '1;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_grant;
    logic [1:0]            w_arb_grant;
    logic                  r_last_served;
    logic [FRAME_LOG2-1:0] r_load_cnt;
    logic [FRAME_LOG2-1:0] r_out_index;
    logic [WCW-1:0]        r_wait_cnt;
    logic                  r_fft_in_valid;
    logic                  r_frame_done;
    logic                  r_timeout_err;
    logic                  w_load_last;
    logic                  w_wait_expired;
    logic                  w_accept;
    logic                  w_last_bin;

    rr_arbiter2 u_rr (
        .i_req         (i_req),
        .i_last_served (r_last_served),
        .o_grant       (w_arb_grant)
    );

    assign w_load_last    = (r_load_cnt == LAST_IDX);
    assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
    assign w_accept       = (r_state == S_DRAIN) && i_out_ready;
    assign w_last_bin     = w_accept && (r_out_index == LAST_IDX);

    assign o_grant        = r_grant;
    assign o_out_ch       = r_grant[1];
    assign o_out_index    = r_out_index;
    assign o_fft_in_valid = r_fft_in_valid;
    assign o_frame_done   = r_frame_done;
    assign o_timeout_err  = r_timeout_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        w_next      = r_state;
        o_fft_start = 1'b0;
        o_rd_en     = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  if (i_req != 2'b00) w_next = S_ARB;
            // A request withdrawn between IDLE and ARB leaves nothing to grant
            S_ARB:   w_next = (w_arb_grant != 2'b00) ? S_START : S_IDLE;
            S_START: begin
                o_fft_start = 1'b1;
                w_next      = S_LOAD;
            end
            S_LOAD: begin
                o_rd_en = 1'b1;
                if (w_load_last) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_fft_done)          w_next = S_DRAIN;
                else if (w_wait_expired) w_next = S_IDLE;
            end
            S_DRAIN: begin
                o_out_valid = 1'b1;
                if (w_last_bin) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, counters, history and status flags
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_grant        <= '0;
            r_last_served  <= 1'b1;
            r_load_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_out_index    <= '0;
            r_fft_in_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_fft_in_valid <= (r_state == S_LOAD);
            r_frame_done   <= w_last_bin;
            if (r_state != S_WAIT) r_wait_cnt <= '0;
            case (r_state)
                S_ARB:   r_grant <= w_arb_grant;
                S_START: r_load_cnt <= '0;
                S_LOAD:  if (!w_load_last) r_load_cnt <= r_load_cnt + 1'b1;
                S_WAIT: begin
                    if (i_fft_done) begin
                        r_out_index <= '0;
                    end else if (w_wait_expired) begin
                        r_timeout_err <= 1'b1;
                        r_last_served <= r_grant[1];
                        r_grant       <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_bin) begin
                        r_last_served <= r_grant[1];
                        r_grant       <= '0;
                    end else if (w_accept) begin
                        r_out_index <= r_out_index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_channel_arbiter.sv
// Self-checking bench for fft_channel_arbiter: per-frame reference model
// (round-robin history, pop/valid counts, bin ordering, timeout length).
module tb_fft_channel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       fft_done;
    logic       out_ready;
    logic [1:0] grant;
    logic       rd_en;
    logic       fft_start;
    logic       fft_in_valid;
    logic       out_valid;
    logic [8:0] out_index;
    logic       out_ch;
    logic       frame_done;
    logic       timeout_err;

    int n_checks;
    int n_errors;
    int m_last;   // reference model: channel served most recently

    fft_channel_arbiter #(
        .FRAME_LOG2   (9),
        .WAIT_TIMEOUT (4096)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_req          (req),
        .o_grant        (grant),
        .o_rd_en        (rd_en),
        .o_fft_start    (fft_start),
        .o_fft_in_valid (fft_in_valid),
        .i_fft_done     (fft_done),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_index    (out_index),
        .o_out_ch       (out_ch),
        .o_frame_done   (frame_done),
        .o_timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({grant, rd_en, fft_start, fft_in_valid, out_valid,
                    out_index, out_ch, frame_done, timeout_err});
    endfunction

    // Round-robin rule: lone request wins; on a tie the other channel wins
    function automatic logic [1:0] exp_grant(input logic [1:0] r, input int last);
        int pick;
        if (r == 2'b11)      pick = 1 - last;
        else if (r == 2'b10) pick = 1;
        else                 pick = 0;
        return (pick == 1) ? 2'b10 : 2'b01;
    endfunction

    // One frame from IDLE; returns at the first IDLE sample afterwards
    task automatic run_frame(input logic [1:0] req_pat, input int ready_mode,
                             input bit give_done, input int abort_at,
                             input int drop_at, input int stray_at);
        logic [1:0] eg;
        logic       ch;
        logic       prev_rd;
        logic       rdy;
        int rd_n, fiv_n, skew_bad, hold_bad, k, d, wait_bad;
        int exp_idx, bad_bins, steps, wcyc;
        bit finished, to_seen;

        eg = exp_grant(req_pat, m_last);
        ch = (eg == 2'b10);
        req = req_pat;
        @(negedge clk);                       // ARB
        chk("arb_grant_zero", 32'(grant), 0);
        chk("arb_no_start", 32'(fft_start), 0);
        chk("frame_done_one_cycle", 32'(frame_done), 0);
        @(negedge clk);                       // START
        chk("start_pulse", 32'(fft_start), 1);
        chk("start_grant", 32'(grant), 32'(eg));
        chk("start_no_rd", 32'(rd_en), 0);

        rd_n = 0; fiv_n = 0; skew_bad = 0; hold_bad = 0; prev_rd = 1'b0;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            fft_done = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("reset_midload_outputs", all_outs(), 0);
                rst_n = 1'b1;
                m_last = 1;
                return;
            end
            if (rd_en)        rd_n++;
            if (fft_in_valid) fiv_n++;
            if (fft_in_valid !== prev_rd) skew_bad++;
            if (grant !== eg || fft_start !== 1'b0 || out_valid !== 1'b0) hold_bad++;
            prev_rd = rd_en;
            if (k == stray_at) fft_done = 1'b1;
            if (k == drop_at)  req = 2'($urandom_range(0, 3));
            if (!rd_en && !fft_in_valid) break;
        end
        chk("rd_en_count", rd_n, 512);
        chk("fft_in_valid_count", fiv_n, 512);
        chk("fft_in_valid_skew", skew_bad, 0);
        chk("load_grant_hold", hold_bad, 0);
        chk("wait_after_stray_done", 32'(out_valid), 0);

        if (give_done) begin
            d = $urandom_range(0, 20);
            wait_bad = 0;
            repeat (d) begin
                @(negedge clk);
                if (out_valid !== 1'b0 || grant !== eg) wait_bad++;
            end
            chk("wait_idle_outputs", wait_bad, 0);
            fft_done = 1'b1;
            @(negedge clk);
            fft_done = 1'b0;

            exp_idx = 0; bad_bins = 0; finished = 0; steps = 0;
            while (!finished && steps < 3000) begin
                if (out_valid !== 1'b1 || out_index !== 9'(exp_idx) || out_ch !== ch ||
                    grant !== eg || frame_done !== 1'b0)
                    bad_bins++;
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = steps[0];
                    default: rdy = ($urandom_range(0, 1) == 1);
                endcase
                out_ready = rdy;
                @(negedge clk);
                steps++;
                if (rdy) begin
                    if (exp_idx == 511) finished = 1;
                    else                exp_idx++;
                end
            end
            out_ready = 1'b0;
            chk("bin_sequence", bad_bins, 0);
            chk("drain_completed", 32'(finished), 1);
            chk("frame_done_pulse", 32'(frame_done), 1);
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_grant_clear", 32'(grant), 0);
            m_last = int'(ch);
        end else begin
            wcyc = 0; to_seen = 0; wait_bad = 0;
            while (!to_seen && wcyc < 5000) begin
                @(negedge clk);
                wcyc++;
                if (timeout_err) to_seen = 1;
                else if (out_valid !== 1'b0 || frame_done !== 1'b0) wait_bad++;
            end
            chk("timeout_wait_cycles", wcyc, 4095);
            chk("timeout_flag", 32'(timeout_err), 1);
            chk("timeout_quiet", wait_bad, 0);
            chk("timeout_grant_clear", 32'(grant), 0);
            chk("timeout_no_frame_done", 32'(frame_done), 0);
            m_last = int'(ch);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_last = 1;
        rst_n = 1'b0; req = 2'b00; fft_done = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'({grant, fft_start, rd_en, out_valid}), 0);

        // Lone channel 0 request
        run_frame(2'b01, 0, 1, -1, -1, -1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        chk("idle_hold", 32'({grant, fft_start, rd_en, out_valid}), 0);

        // Reset in the middle of a load, then a tie must go to channel 0
        run_frame(2'b11, 0, 1, 200, -1, -1);
        run_frame(2'b11, 0, 1, -1, -1, -1);
        run_frame(2'b11, 0, 1, -1, -1, -1);
        run_frame(2'b11, 0, 1, -1, -1, -1);

        // Back-pressure toggling every other cycle
        run_frame(2'b10, 1, 1, -1, -1, -1);

        // No fft_done: timeout, then normal arbitration continues
        run_frame(2'b11, 0, 0, -1, -1, -1);
        run_frame(2'b11, 0, 1, -1, -1, -1);
        chk("timeout_sticky", 32'(timeout_err), 1);

        // Request dropped mid-load and a stray fft_done during load
        run_frame(2'b01, 0, 1, -1, 100, 300);

        // Randomised frames
        for (int f = 0; f < 4; f++) begin
            run_frame(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1, -1,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 500)) : -1,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 500)) : -1);
        end

        req = 2'b00;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
